// File: rtl/pipeline_pkg.sv
// Pipeline-wide constants shared by decode, forwarding and the register scoreboard.
package pipeline_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;

    // Producer latencies; the forwarding unit reads the same values.
    localparam int DEF_LOAD_LAT = 3;
    localparam int DEF_ALU_LAT  = 0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/sb_entry.sv
// One scoreboard slot: saturating down-counter, reloaded on issue, pending while non-zero.
module sb_entry #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             pending
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A reload beats the decrement so a newer producer always wins.
    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign pending = (cnt_q != '0);
endmodule

// File: rtl/reg_scoreboard.sv
// Latency-driven register-pending scoreboard at the ID/issue boundary; raises stall
// while a source operand of the instruction in ID is not yet forwardable.
module reg_scoreboard
    import pipeline_pkg::*;
#(
    parameter int LOAD_LAT = DEF_LOAD_LAT,
    parameter int ALU_LAT  = DEF_ALU_LAT,
    parameter int CNT_W    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic        issue_wena,
    input  logic        issue_is_load,
    input  logic [4:0]  issue_waddr,
    input  logic        flush,
    input  logic        dec_valid,
    input  logic [31:0] dec_inst,
    output logic        stall,
    output logic [31:0] busy_mask
);
    logic                issue_acc;
    logic [CNT_W-1:0]    issue_lat;
    logic [NUM_REGS-1:0] pending;
    reg_addr_t           rs, rt;
    logic                unused_inst_bits;

    always_comb begin
        issue_acc = issue_valid && issue_wena && !flush && (issue_waddr != '0);
        issue_lat = issue_is_load ? CNT_W'(LOAD_LAT) : CNT_W'(ALU_LAT);
    end

    // r0 is hardwired zero and never needs tracking.
    assign pending[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        sb_entry #(.CNT_W(CNT_W)) u_entry (
            .clk      (clk),
            .rst      (rst),
            .load     (issue_acc && (issue_waddr == REG_ADDR_W'(r))),
            .load_val (issue_lat),
            .pending  (pending[r])
        );
    end

    // rt is checked even for instructions that ignore it; the extra stall is harmless.
    always_comb begin
        rs    = dec_inst[RS_MSB:RS_LSB];
        rt    = dec_inst[RT_MSB:RT_LSB];
        stall = dec_valid && (((rs != '0) && pending[rs]) || ((rt != '0) && pending[rt]));
    end

    assign busy_mask        = pending;
    assign unused_inst_bits = ^{dec_inst[31:26], dec_inst[15:0]};
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed + random bench for reg_scoreboard with a pending-window reference model.
module tb_reg_scoreboard;
    localparam int LOAD_LAT = 3;
    localparam int ALU_LAT  = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_wena, issue_is_load, flush, dec_valid;
    logic [4:0]  issue_waddr;
    logic [31:0] dec_inst;
    logic        stall;
    logic [31:0] busy_mask;

    typedef struct packed {
        logic        st;
        logic [31:0] mask;
    } exp_t;

    exp_t q[$];
    int   last_pend[32];   // last cycle in which register r is pending
    int   cyc_n = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    reg_scoreboard #(.LOAD_LAT(LOAD_LAT), .ALU_LAT(ALU_LAT), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_wena(issue_wena),
        .issue_is_load(issue_is_load), .issue_waddr(issue_waddr), .flush(flush),
        .dec_valid(dec_valid), .dec_inst(dec_inst), .stall(stall), .busy_mask(busy_mask)
    );

    // One pipeline cycle: drive at negedge, check mid-low-phase, advance model at the edge.
    task automatic cyc(input logic r, input logic iv, input logic we, input logic ld,
                       input logic [4:0] wa, input logic fl, input logic dv,
                       input logic [4:0] rs, input logic [4:0] rt, input string tag);
        exp_t e, got;
        @(negedge clk);
        e.mask = '0;
        for (int k = 1; k < 32; k++) e.mask[k] = (cyc_n <= last_pend[k]);
        e.st = dv && (((rs != 0) && e.mask[rs]) || ((rt != 0) && e.mask[rt]));
        rst           = r;
        issue_valid   = iv && !e.st;
        issue_wena    = we;
        issue_is_load = ld;
        issue_waddr   = wa;
        flush         = fl;
        dec_valid     = dv;
        dec_inst      = {6'($urandom), rs, rt, 16'($urandom)};
        q.push_back(e);
        #2;
        got = q.pop_front();
        n_assert++;
        assert (stall === got.st) else begin
            n_fail++;
            $error("FAIL %s stall: observed %0b expected %0b (cycle %0d)", tag, stall, got.st, cyc_n);
        end
        n_assert++;
        assert (busy_mask === got.mask) else begin
            n_fail++;
            $error("FAIL %s busy_mask: observed %h expected %h (cycle %0d)", tag, busy_mask, got.mask, cyc_n);
        end
        n_assert++;
        assert (!(issue_valid && stall)) else begin
            n_fail++;
            $error("FAIL %s protocol: issue_valid with stall observed %0b expected 0", tag, issue_valid && stall);
        end
        if (r) begin
            for (int k = 0; k < 32; k++) last_pend[k] = -1;
        end else if (issue_valid && we && !fl && wa != 0) begin
            last_pend[wa] = cyc_n + (ld ? LOAD_LAT : ALU_LAT);
        end
        cyc_n++;
    endtask

    initial begin
        for (int k = 0; k < 32; k++) last_pend[k] = -1;
        rst = 1'b1; issue_valid = 0; issue_wena = 0; issue_is_load = 0;
        issue_waddr = 0; flush = 0; dec_valid = 0; dec_inst = 0;
        repeat (2) @(posedge clk);

        // Reset then idle
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 0, 1, 5, 6, "idle");

        // Load-use on r8; same-cycle read of the issuing register must not stall
        cyc(0, 1, 1, 1, 8, 0, 1, 8, 0, "ld_issue");
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 1, 8, 0, "load_use");

        // ALU producer, zero latency
        cyc(0, 1, 1, 0, 9, 0, 1, 3, 3, "alu_issue");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1, 9, 9, "alu_use");

        // r0 never tracked
        cyc(0, 1, 1, 1, 0, 0, 0, 0, 0, "r0_issue");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, "r0_use");

        // Flushed issue is dropped
        cyc(0, 1, 1, 1, 10, 1, 0, 0, 0, "flush_issue");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 1, 10, 10, "flush_use");

        // Non-writing issue is ignored
        cyc(0, 1, 0, 1, 11, 0, 0, 0, 0, "nowena_issue");
        cyc(0, 0, 0, 0, 0, 0, 1, 11, 0, "nowena_use");

        // WAW overwrite on r4: pending through T+5, clear at T+6
        cyc(0, 1, 1, 1, 4, 0, 1, 7, 7, "waw_t0");
        cyc(0, 0, 0, 0, 0, 0, 1, 7, 7, "waw_t1");
        cyc(0, 1, 1, 1, 4, 0, 1, 7, 7, "waw_t2");
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 1, 0, 4, "waw_use");

        // Reset mid-countdown, with a simultaneous issue that reset must override
        cyc(0, 1, 1, 1, 12, 0, 0, 0, 0, "rst_issue");
        cyc(1, 1, 1, 1, 13, 0, 0, 12, 13, "rst_edge");
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 1, 12, 13, "rst_after");

        // Random traffic
        for (int i = 0; i < 300; i++)
            cyc(($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
                5'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0), 1'($urandom),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), "random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
